// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, per-mode key-schedule sizes, S-box and xtime helpers
package aes_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {AES128 = 2'b00, AES192 = 2'b01, AES256 = 2'b10, AES_ILL = 2'b11} aes_mode_e;
  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} ks_state_e;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  function automatic logic [3:0] nk_of(input aes_mode_e m);
    return m == AES192 ? 4'd6 : m == AES256 ? 4'd8 : 4'd4;
  endfunction
  function automatic logic [3:0] nr_of(input aes_mode_e m);
    return nk_of(m) + 4'd6;
  endfunction
  function automatic logic [5:0] wtot_of(input aes_mode_e m);
    return {nr_of(m) + 4'd1, 2'b00};
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[8*(255-int'(b)) +: 8];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/aes_sub_word.sv
// aes_sub_word: four parallel S-box lookups on a 32-bit word
module aes_sub_word
  import aes_pkg::*;
(
  input  word_t a,
  output word_t y
);
  assign y = {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
endmodule

// File: rtl/aes_key_sched.sv
// aes_key_sched: iterative 128/192/256-bit AES key expansion, one word per cycle, indexed round-key read
module aes_key_sched
  import aes_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256,
  parameter bit RD_REG = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    key_v_i,
  output logic                    key_ready_o,
  input  logic [1:0]              mode_i,
  input  logic [0:MAX_KEY_BITS-1] key_i,
  output logic                    err_o,
  output logic                    done_o,
  input  logic [3:0]              rk_idx_i,
  output logic [0:127]            rk_o,
  output logic                    rk_valid_o
);
  localparam int MAX_NK = MAX_KEY_BITS / 32;
  localparam int WMAX = 4 * (MAX_NK + 7);
  ks_state_e state, state_n;
  aes_mode_e m_in, mode_q;
  word_t w [WMAX];
  word_t prev, back, sw_in, sw_out, temp, new_w;
  logic [5:0] i, b;
  logic [3:0] j, nk_q;
  logic [7:0] rcon;
  logic legal, accept, last;
  logic [0:127] rk_c;
  logic rv_c;
  assign m_in = aes_mode_e'(mode_i);
  assign nk_q = nk_of(mode_q);
  assign legal = m_in != AES_ILL && 32 * int'(nk_of(m_in)) <= MAX_KEY_BITS;
  assign accept = key_v_i && key_ready_o && legal;
  assign last = i == wtot_of(mode_q) - 6'd1;
  // j tracks i mod Nk so no divider is needed for the 192-bit mode
  always_comb begin
    prev = w[i - 6'd1];
    back = w[i - 6'(nk_q)];
    sw_in = j == 4'd0 ? {prev[23:0], prev[31:24]} : prev;
    temp = j == 4'd0 ? sw_out ^ {rcon, 24'h0} : (nk_q == 4'd8 && j == 4'd4) ? sw_out : prev;
    new_w = back ^ temp;
  end
  aes_sub_word u_sub (.a(sw_in), .y(sw_out));
  // state register
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) state <= S_IDLE;
    else state <= state_n;
  // next state: accept from IDLE/DONE, leave EXPAND on the last word
  always_comb begin
    state_n = state;
    if (accept) state_n = S_EXPAND;
    else if (state == S_EXPAND && last) state_n = S_DONE;
  end
  // handshake and status outputs
  always_comb begin
    key_ready_o = state != S_EXPAND;
    done_o = state == S_DONE;
  end
  // word counter, Nk phase, rcon, latched mode and error pulse
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      i <= '0;
      j <= '0;
      rcon <= 8'h01;
      mode_q <= AES128;
      err_o <= 1'b0;
    end else begin
      err_o <= key_v_i && key_ready_o && !legal;
      if (accept) begin
        i <= 6'(nk_of(m_in));
        j <= '0;
        rcon <= 8'h01;
        mode_q <= m_in;
      end else if (state == S_EXPAND) begin
        i <= i + 6'd1;
        j <= j == nk_q - 4'd1 ? 4'd0 : j + 4'd1;
        if (j == 4'd0) rcon <= xtime(rcon);
      end
    end
  // round-key store: cipher key loaded in one edge, then one expanded word per edge
  always_ff @(posedge clk_i)
    if (accept) begin
      for (int k = 0; k < MAX_NK; k++)
        if (k < int'(nk_of(m_in))) w[k] <= key_i[32*k +: 32];
    end else if (state == S_EXPAND) w[i] <= new_w;
  // indexed read of four consecutive words; nothing meaningful before the first accept
  always_comb begin
    b = {rk_idx_i, 2'b00};
    rv_c = done_o && rk_idx_i <= nr_of(mode_q);
    rk_c = (state != S_IDLE && rk_idx_i <= nr_of(mode_q)) ? {w[b], w[b + 6'd1], w[b + 6'd2], w[b + 6'd3]} : '0;
  end
  generate
    if (RD_REG) begin : g_rd_reg
      // registered read port
      always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
          rk_o <= '0;
          rk_valid_o <= 1'b0;
        end else begin
          rk_o <= rk_c;
          rk_valid_o <= rv_c;
        end
    end else begin : g_rd_comb
      assign rk_o = rk_c;
      assign rk_valid_o = rv_c;
    end
  endgenerate
endmodule
